// File: rtl/lab62_pio_pkg.sv
// Shared constants for the lab62 input PIO: the register map and the edge-capture modes.
package lab62_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/lab62_pio_debounce.sv
// One input bit: a synchronizer chain, a stability counter and the debounced level flop.
module lab62_pio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic db,
  output logic db_next
);

  localparam int unsigned     CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;
  logic                   settle;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign settle  = (sync != db) && (cnt == CNT_LAST);
  assign db_next = settle ? sync : db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt    <= '0;
      db     <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      db     <= db_next;
      // Any return to the current level restarts the stability window.
      if ((sync == db) || settle)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lab62_keys_edge_pio.sv
// Avalon-MM input PIO: debounced levels, per-bit edge capture with W1C, maskable level irq.
module lab62_keys_edge_pio
  import lab62_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE            = EDGE_FALLING,
  parameter logic [WIDTH-1:0] DB_RESET        = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] evt_q;
  logic [WIDTH-1:0] ecap;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lab62_pio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (DB_RESET[i])
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .din     (in_port[i]),
      .db      (db[i]),
      .db_next (db_next[i])
    );
  end

  always_comb begin
    evt = '0;
    if (EDGE == EDGE_RISING)
      evt = db_next & ~db;
    else if (EDGE == EDGE_FALLING)
      evt = ~db_next & db;
    else
      evt = db_next ^ db;
  end

  assign wr           = chipselect && !write_n;
  assign clr          = (wr && (address == PIO_ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // Events are staged one cycle so capture lands the edge after db moves; set beats W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q <= '0;
      ecap  <= '0;
      mask  <= '0;
    end else begin
      evt_q <= evt;
      ecap  <= (ecap & ~clr) | evt_q;
      if (wr && (address == PIO_ADDR_IRQMASK))
        mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(ecap & mask);

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata = 32'(db);
      PIO_ADDR_IRQMASK: readdata = 32'(mask);
      PIO_ADDR_EDGECAP: readdata = 32'(ecap);
      default:          readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lab62_keys_edge_pio.sv
// Bench for lab62_keys_edge_pio: register table plus debounce/edge/irq sequences.
module tb_lab62_keys_edge_pio;
  import lab62_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  lab62_keys_edge_pio #(
    .WIDTH           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .EDGE            (EDGE_FALLING),
    .DB_RESET        (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic compare_front(input logic [31:0] act);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %h, required a queued expectation", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %h, required %h", e.name, act, e.val);
      end
    end
  endtask

  task automatic rd(input string n, input logic [1:0] a, input logic [31:0] v);
    expect_val(n, v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    compare_front(readdata);
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input string n, input logic v);
    expect_val(n, {31'b0, v});
    #1;
    compare_front({31'b0, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    tbl[0] = '{"rst_data",      1'b0, 2'd0, 32'h0,        PIO_ADDR_DATA,    32'h0000000F};
    tbl[1] = '{"rst_addr1",     1'b0, 2'd0, 32'h0,        PIO_ADDR_DIR,     32'h0};
    tbl[2] = '{"rst_mask",      1'b0, 2'd0, 32'h0,        PIO_ADDR_IRQMASK, 32'h0};
    tbl[3] = '{"rst_ecap",      1'b0, 2'd0, 32'h0,        PIO_ADDR_EDGECAP, 32'h0};
    tbl[4] = '{"wr_data_ign",   1'b1, PIO_ADDR_DATA, 32'h0,        PIO_ADDR_DATA,    32'h0000000F};
    tbl[5] = '{"wr_addr1_ign",  1'b1, PIO_ADDR_DIR,  32'hFFFFFFFF, PIO_ADDR_DIR,     32'h0};
    tbl[6] = '{"mask_wr_5",     1'b1, PIO_ADDR_IRQMASK, 32'hFFFFFFF5, PIO_ADDR_IRQMASK, 32'h5};
    tbl[7] = '{"mask_wr_A",     1'b1, PIO_ADDR_IRQMASK, 32'h0000000A, PIO_ADDR_IRQMASK, 32'hA};
    tbl[8] = '{"mask_wr_0",     1'b1, PIO_ADDR_IRQMASK, 32'h0,        PIO_ADDR_IRQMASK, 32'h0};
    tbl[9] = '{"ecap_w1c_idle", 1'b1, PIO_ADDR_EDGECAP, 32'h0000000F, PIO_ADDR_EDGECAP, 32'h0};

    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    reset = 1'b0;
    tick();

    chk_irq("rst_irq", 1'b0);
    for (int i = 0; i < $size(tbl); i++) begin
      if (tbl[i].wr) wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].name, tbl[i].ra, tbl[i].exp);
    end
    chk_irq("table_irq", 1'b0);

    // Falling edge on bit 2 with interrupt enabled
    wr(PIO_ADDR_IRQMASK, 32'h4);
    in_port = 4'hB;
    tick(5);
    rd("fall_data_k4", PIO_ADDR_DATA, 32'hF);
    tick();
    rd("fall_data_k5", PIO_ADDR_DATA, 32'hB);
    rd("fall_ecap_k5", PIO_ADDR_EDGECAP, 32'h0);
    chk_irq("fall_irq_k5", 1'b0);
    tick();
    rd("fall_ecap_k6", PIO_ADDR_EDGECAP, 32'h4);
    chk_irq("fall_irq_k6", 1'b1);
    wr(PIO_ADDR_EDGECAP, 32'h4);
    rd("fall_ecap_clr", PIO_ADDR_EDGECAP, 32'h0);
    chk_irq("fall_irq_clr", 1'b0);

    // Rising back to idle is not captured in falling mode
    in_port = 4'hF;
    tick(8);
    rd("rise_data", PIO_ADDR_DATA, 32'hF);
    rd("rise_ecap", PIO_ADDR_EDGECAP, 32'h0);

    // Glitch shorter than the debounce window
    in_port = 4'hB;
    tick(3);
    in_port = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      rd("glitch_data", PIO_ADDR_DATA, 32'hF);
    end
    rd("glitch_ecap", PIO_ADDR_EDGECAP, 32'h0);
    chk_irq("glitch_irq", 1'b0);

    // Masked event, then unmask
    wr(PIO_ADDR_IRQMASK, 32'h0);
    in_port = 4'hE;
    tick(7);
    rd("masked_ecap", PIO_ADDR_EDGECAP, 32'h1);
    chk_irq("masked_irq", 1'b0);
    wr(PIO_ADDR_IRQMASK, 32'hF);
    chk_irq("unmask_irq", 1'b1);
    wr(PIO_ADDR_EDGECAP, 32'h1);
    chk_irq("unmask_irq_clr", 1'b0);
    in_port = 4'hF;
    tick(8);

    // W1C landing on the same edge that sets ecap[1]
    in_port = 4'hD;
    tick(6);
    rd("coll_ecap_pre", PIO_ADDR_EDGECAP, 32'h0);
    wr(PIO_ADDR_EDGECAP, 32'h2);
    rd("coll_ecap", PIO_ADDR_EDGECAP, 32'h2);
    chk_irq("coll_irq", 1'b1);
    wr(PIO_ADDR_EDGECAP, 32'h2);
    rd("coll_ecap_clr", PIO_ADDR_EDGECAP, 32'h0);
    in_port = 4'hF;
    tick(8);
    rd("coll_rise_ecap", PIO_ADDR_EDGECAP, 32'h0);
    chk_irq("coll_rise_irq", 1'b0);

    // Reset while a change is pending
    in_port = 4'hE;
    tick(4);
    reset   = 1'b1;
    in_port = 4'hF;
    tick();
    reset = 1'b0;
    rd("rmid_data", PIO_ADDR_DATA, 32'hF);
    rd("rmid_ecap", PIO_ADDR_EDGECAP, 32'h0);
    rd("rmid_mask", PIO_ADDR_IRQMASK, 32'h0);
    chk_irq("rmid_irq", 1'b0);
    tick(8);
    rd("rmid_data_late", PIO_ADDR_DATA, 32'hF);
    rd("rmid_ecap_late", PIO_ADDR_EDGECAP, 32'h0);
    chk_irq("rmid_irq_late", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lab62_keys_edge_pio.md
# lab62_keys_edge_pio

Memory-mapped input PIO: the read-side counterpart of the design's output PIOs, and a slave on the same Nios II Avalon-MM fabric. It synchronizes and debounces a bank of external inputs (KEY buttons, switches) and presents the clean level to software. Per-bit edge-capture latches record events, and a maskable level interrupt goes to the Nios II IRQ controller. Software reads levels and edges, masks interrupts and clears captured edges.

## Interface
- `WIDTH`, 4: number of input bits (1..32).
- `SYNC_STAGES`, 2: synchronizer flops per bit (≥2).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed before the debounced level changes (≥1; 1 = no filtering).
- `EDGE`, 1: captured edge type; 0 = rising, 1 = falling, 2 = any.
- `DB_RESET`, all ones: reset value of the debounced level (active-low keys idle high).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data, zero-extended above `WIDTH`.
- `in_port` in `WIDTH`: asynchronous external inputs.
- `irq` out 1: level interrupt, active high.

## Operation
- Register map:
  - 0 DATA (RO): debounced level `db`.
  - 1: reads 0, writes ignored.
  - 2 IRQMASK (RW): `mask`.
  - 3 EDGECAP (R, write-1-to-clear): `ecap`.
- Writes to 0 and 1 have no effect.
- Write condition: `chipselect && !write_n`. Reads have no side effects.
- `readdata` is a combinational mux of `address`. Bits `[31:WIDTH]` are 0.
- Per-bit conditioning:
  - `sync` is the `SYNC_STAGES`-flop chain output.
  - A counter increments while `sync != db` and clears whenever `sync == db`.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, the next edge loads `db <= sync` and clears the counter.
  - A mismatch shorter than `DEBOUNCE_CYCLES` cycles never changes `db`.
- Edge detect compares `db` (next value) against `db` (current value). A qualifying transition per `EDGE` sets `ecap[i]` on the edge after `db` changes.
- Set/clear conflict: a W1C to EDGECAP and a new edge on the same bit in the same cycle leave the bit set. The set wins, so no event is lost.
- `irq = |(ecap & mask)`, decoded from registers only, with no glitch paths from the bus.
- Reset values:
  - sync chain = `DB_RESET`
  - counters = 0
  - `db` = `DB_RESET`
  - `ecap` = 0, `mask` = 0
  - `irq` = 0
  - `readdata` follows `address` with these values.
- Reset mid-debounce discards the pending change, and no edge is recorded.

## Timing
- `in_port` is sampled at edge k:
  - `sync` valid after edge k+SYNC_STAGES-1.
  - `db` updates at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - `ecap` sets at the following edge.
  - `irq` rises in that same cycle if the bit is masked in.
- IRQMASK and EDGECAP writes take effect at the write edge. `irq` reflects the change in the next cycle.
- Read latency is 0 (combinational `readdata`); no wait states.
- Throughput: one access per cycle.

## Structure
- Package `lab62_pio_pkg` holds:
  - address constants `PIO_ADDR_DATA`/`_DIR`/`_IRQMASK`/`_EDGECAP`
  - edge-type constants `EDGE_RISING`/`_FALLING`/`_ANY`
- Sub-module `lab62_pio_debounce`: one bit of synchronizer plus counter plus `db` flop. It takes parameters `SYNC_STAGES`, `DEBOUNCE_CYCLES` and `RESET_VAL`, and outputs `db` and `db_next`.
- `lab62_keys_edge_pio` instantiates it `WIDTH` times and contains the register file, edge logic and irq.

## Test plan
Bench configuration: `WIDTH`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `EDGE`=falling.
- **Reset:** `in_port`=0xF, reset pulsed → DATA reads 0x0000000F, IRQMASK and EDGECAP read 0, address 1 reads 0, `irq`=0.
- **Falling edge with interrupt:**
  - Write IRQMASK=0x4, then `in_port`=0xB held from edge k.
  - DATA reads 0xB after edge k+5, EDGECAP reads 0x4 and `irq`=1 after edge k+6.
  - Write EDGECAP=0x4 → EDGECAP=0 and `irq`=0 the following cycle.
- **Glitch rejection:** `in_port`=0xB for 3 cycles then back to 0xF → DATA stays 0xF, EDGECAP stays 0, `irq` stays 0.
- **Masked event:**
  - IRQMASK=0, bit 0 falls → EDGECAP=0x1 and `irq`=0.
  - Then write IRQMASK=0xF → `irq`=1 the next cycle.
- **Set/clear collision:** a W1C of 0x2 lands on the same edge that `ecap[1]` would set → EDGECAP reads 0x2 afterwards. A rising edge on any bit leaves EDGECAP unchanged.
- **Reset mid-debounce:** `in_port`=0xE held 2 cycles past sync, then reset asserted for 1 cycle with `in_port` returned to 0xF → DATA=0xF, EDGECAP=0, no `irq`.
